// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator
// Free-running 640x480@60Hz raster timing generator. hpos/vpos count the
// raster, hsync/vsync are registered range compares of the current counters
// (one clock behind them), display_on marks the visible area with no latency.
// Build option: define HVSYNC_POSITIVE_POLARITY_EN for active-high sync
// pulses (reset value 0); the default build drives active-low sync
// (reset value 1). Counters and display_on are the same in both builds.

module vga_hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam logic [9:0] H_DISP_C       = 10'(H_DISPLAY);
    localparam logic [9:0] H_MAX_C        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_SYNC_START_C = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END_C   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_DISP_C       = 10'(V_DISPLAY);
    localparam logic [9:0] V_MAX_C        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [9:0] V_SYNC_START_C = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END_C   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

`ifdef HVSYNC_POSITIVE_POLARITY_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif

    // Visible-area flag for the counter state right after reset (0,0).
    localparam logic DISPLAY_RST = (H_DISPLAY > 0) && (V_DISPLAY > 0);

    logic [9:0] hpos_r;
    logic [9:0] vpos_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       display_on_r;

    logic       h_wrap_s;
    logic [9:0] hpos_next_s;
    logic [9:0] vpos_next_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       display_on_next_s;

    // Next-state raster counters: hpos wraps at H_MAX, vpos steps only on that wrap.
    always_comb begin
        h_wrap_s    = (hpos_r == H_MAX_C);
        hpos_next_s = hpos_r;
        vpos_next_s = vpos_r;
        if (h_wrap_s) begin
            hpos_next_s = 10'd0;
            if (vpos_r == V_MAX_C) begin
                vpos_next_s = 10'd0;
            end else begin
                vpos_next_s = vpos_r + 10'd1;
            end
        end else begin
            hpos_next_s = hpos_r + 10'd1;
            vpos_next_s = vpos_r;
        end
    end

    // Sync levels are range compares on the current counters, so the
    // registered pulses trail the counters by one clock.
    always_comb begin
        hsync_next_s = ~SYNC_ACTIVE;
        vsync_next_s = ~SYNC_ACTIVE;
        if ((hpos_r >= H_SYNC_START_C) && (hpos_r <= H_SYNC_END_C)) begin
            hsync_next_s = SYNC_ACTIVE;
        end else begin
            hsync_next_s = ~SYNC_ACTIVE;
        end
        if ((vpos_r >= V_SYNC_START_C) && (vpos_r <= V_SYNC_END_C)) begin
            vsync_next_s = SYNC_ACTIVE;
        end else begin
            vsync_next_s = ~SYNC_ACTIVE;
        end
    end

    // display_on is evaluated on the next counter values and registered
    // alongside them, so it lines up with hpos/vpos with zero latency.
    always_comb begin
        display_on_next_s = 1'b0;
        if ((hpos_next_s < H_DISP_C) && (vpos_next_s < V_DISP_C)) begin
            display_on_next_s = 1'b1;
        end else begin
            display_on_next_s = 1'b0;
        end
    end

    // State update; reset overrides counting on every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_r       <= 10'd0;
            vpos_r       <= 10'd0;
            hsync_r      <= ~SYNC_ACTIVE;
            vsync_r      <= ~SYNC_ACTIVE;
            display_on_r <= DISPLAY_RST;
        end else begin
            hpos_r       <= hpos_next_s;
            vpos_r       <= vpos_next_s;
            hsync_r      <= hsync_next_s;
            vsync_r      <= vsync_next_s;
            display_on_r <= display_on_next_s;
        end
    end

    assign hpos       = hpos_r;
    assign vpos       = vpos_r;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign display_on = display_on_r;

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Testbench for vga_hvsync_generator. Instance a uses the 640x480 timing;
// instance b keeps the horizontal timing but uses a 10-line frame
// (4 visible, 2 porch, 2 sync, 2 back) so a full frame, vsync pulse and
// frame wrap fit in a short run. Time t counts clocks since reset release.

module tb_vga_hvsync_generator;

`ifdef HVSYNC_POSITIVE_POLARITY_EN
    localparam logic POL_X = 1'b1;
`else
    localparam logic POL_X = 1'b0;
`endif
    // Level of an asserted sync pulse in this build.
    localparam logic ACT = 1'b0 ^ POL_X;

    typedef struct {
        int         epoch;
        int         t;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    logic [9:0] hp_a, vp_a, hp_b, vp_b;

    int   t = 0;
    int   epoch = 0;
    logic in_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt_l0 = 0, hs_cnt_l1 = 0, de_cnt_a = 0, vs_cnt_b = 0, de_cnt_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    vga_hvsync_generator dut_a (
        .clk(clk), .reset(reset), .hsync(hs_a), .vsync(vs_a),
        .display_on(de_a), .hpos(hp_a), .vpos(vp_a)
    );

    vga_hvsync_generator #(
        .V_DISPLAY(4), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2)
    ) dut_b (
        .clk(clk), .reset(reset), .hsync(hs_b), .vsync(vs_b),
        .display_on(de_b), .hpos(hp_b), .vpos(vp_b)
    );

    always #20 clk = ~clk;

    // Clock-since-release counter and reset-epoch tracker.
    always @(posedge clk) begin
        if (reset) begin
            t <= 0;
            if (!in_rst) epoch <= epoch + 1;
            in_rst <= 1'b1;
        end else begin
            t <= t + 1;
            in_rst <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d epoch=%0d)", name, act, exp, t, epoch);
        end
    endtask

    // hs/vs arguments are levels for the default (active-low) build.
    task automatic push_a(input int ep, input int tt, input int h, input int v,
                          input logic hs, input logic vs, input logic de);
        q_a.push_back('{ep, tt, 10'(h), 10'(v), hs ^ POL_X, vs ^ POL_X, de});
    endtask

    task automatic push_b(input int ep, input int tt, input int h, input int v,
                          input logic hs, input logic vs, input logic de);
        q_b.push_back('{ep, tt, 10'(h), 10'(v), hs ^ POL_X, vs ^ POL_X, de});
    endtask

    task automatic cmp(input string inst, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic de);
        chk({inst, "_hpos"}, h, e.h);
        chk({inst, "_vpos"}, v, e.v);
        chk({inst, "_hsync"}, hs, e.hs);
        chk({inst, "_vsync"}, vs, e.vs);
        chk({inst, "_display_on"}, de, e.de);
    endtask

    // Monitor: compare when the queue head matches the current time, and
    // accumulate pulse/active counts over the first line(s)/frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (q_a.size() > 0 && q_a[0].epoch == epoch && q_a[0].t == t) begin
                cmp("a", q_a[0], hp_a, vp_a, hs_a, vs_a, de_a);
                void'(q_a.pop_front());
            end
            if (q_b.size() > 0 && q_b[0].epoch == epoch && q_b[0].t == t) begin
                cmp("b", q_b[0], hp_b, vp_b, hs_b, vs_b, de_b);
                void'(q_b.pop_front());
            end
            if (epoch == 1) begin
                if (t < 800) begin
                    if (hs_a == ACT) hs_cnt_l0++;
                    if (de_a) de_cnt_a++;
                end
                if (t >= 800 && t < 1600 && hs_a == ACT) hs_cnt_l1++;
                if (t < 8000) begin
                    if (vs_b == ACT) vs_cnt_b++;
                    if (de_b) de_cnt_b++;
                end
            end
        end
    end

    initial begin
        // Instance a: line timing, hsync pulse edges, line wrap.
        push_a(1, 0,    0,   0, 1'b1, 1'b1, 1'b1);
        push_a(1, 1,    1,   0, 1'b1, 1'b1, 1'b1);
        push_a(1, 639,  639, 0, 1'b1, 1'b1, 1'b1);
        push_a(1, 640,  640, 0, 1'b1, 1'b1, 1'b0);
        push_a(1, 656,  656, 0, 1'b1, 1'b1, 1'b0);
        push_a(1, 657,  657, 0, 1'b0, 1'b1, 1'b0);
        push_a(1, 752,  752, 0, 1'b0, 1'b1, 1'b0);
        push_a(1, 753,  753, 0, 1'b1, 1'b1, 1'b0);
        push_a(1, 799,  799, 0, 1'b1, 1'b1, 1'b0);
        push_a(1, 800,  0,   1, 1'b1, 1'b1, 1'b1);
        push_a(1, 1457, 657, 1, 1'b0, 1'b1, 1'b0);
        push_a(1, 1553, 753, 1, 1'b1, 1'b1, 1'b0);
        push_a(1, 2399, 799, 2, 1'b1, 1'b1, 1'b0);
        push_a(1, 2400, 0,   3, 1'b1, 1'b1, 1'b1);
        // Instance b: 10-line frame, vsync after lines 6..7, frame wrap.
        push_b(1, 3199, 799, 3, 1'b1, 1'b1, 1'b0);
        push_b(1, 3200, 0,   4, 1'b1, 1'b1, 1'b0);
        push_b(1, 4800, 0,   6, 1'b1, 1'b1, 1'b0);
        push_b(1, 4801, 1,   6, 1'b1, 1'b0, 1'b0);
        push_b(1, 6400, 0,   8, 1'b1, 1'b0, 1'b0);
        push_b(1, 6401, 1,   8, 1'b1, 1'b1, 1'b0);
        push_b(1, 7999, 799, 9, 1'b1, 1'b1, 1'b0);
        push_b(1, 8000, 0,   0, 1'b1, 1'b1, 1'b1);
        push_b(1, 8001, 1,   0, 1'b1, 1'b1, 1'b1);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Run to hpos=700 with both sync pulses asserted in instance b
        // (line 7 of its second frame) and hsync asserted in instance a.
        for (int i = 0; i < 20000 && t != 14300; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_reset_point", t, 14300);
        chk("hsync_low_clocks_line0", hs_cnt_l0, 96);
        chk("hsync_low_clocks_line1", hs_cnt_l1, 96);
        chk("display_on_clocks_line0", de_cnt_a, 640);
        chk("vsync_low_clocks_frame_b", vs_cnt_b, 1600);
        chk("display_on_clocks_frame_b", de_cnt_b, 2560);

        // Mid-line, mid-frame reset held for 3 clocks.
        push_a(2, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        push_a(2, 1, 1, 0, 1'b1, 1'b1, 1'b1);
        push_b(2, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        push_b(2, 1, 1, 0, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 50 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
